frame_capture: RTL and testbench



---
 rtl/frame_capture_if.sv | 32 +++
 rtl/frame_capture.sv | 149 ++++++++++++++
 tb/tb_frame_capture.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/frame_capture_if.sv
// Pixel-in / frame-out bundle for frame_capture.
// Carries the filter pixel stream, the capture control and the reader handshake.
// slave = capture block, master = upstream filter plus host reader.
interface frame_capture_if #(
   parameter int WIDTH     = 8,
   parameter int LINE_BITS = 10
);
   logic [WIDTH-1:0]     r_data_in;
   logic [WIDTH-1:0]     g_data_in;
   logic [WIDTH-1:0]     b_data_in;
   logic                 data_in_done;
   logic                 start;
   logic                 busy;
   logic                 frame_ready;
   logic                 overflow;
   logic                 rd_valid;
   logic                 rd_ready;
   logic [3*WIDTH-1:0]   rd_data;
   logic [LINE_BITS-1:0] rd_row;
   logic [LINE_BITS-1:0] rd_col;
   logic                 rd_last;

   modport slave (
      input  r_data_in, g_data_in, b_data_in, data_in_done, start, rd_ready,
      output busy, frame_ready, overflow, rd_valid, rd_data, rd_row, rd_col, rd_last
   );

   modport master (
      output r_data_in, g_data_in, b_data_in, data_in_done, start, rd_ready,
      input  busy, frame_ready, overflow, rd_valid, rd_data, rd_row, rd_col, rd_last
   );
endinterface

// File: rtl/frame_capture.sv
// Captures one ROWS x COLS RGB frame after start, then replays it to a reader.
// Latency: frame_ready 1 cycle after last strobe, first rd_valid 2 cycles after it; 1 pixel / 2 cycles.
// Backpressure: rd_ready low holds the presented pixel; input strobes cannot be stalled and are dropped (overflow) while draining.
module frame_capture #(
   parameter int WIDTH     = 8,
   parameter int ROWS      = 5,
   parameter int COLS      = 6,
   parameter int ADDR_BITS = 5,
   parameter int LINE_BITS = 10
) (
   input  logic           clk,
   input  logic           reset,
   frame_capture_if.slave bus
);

   localparam int DEPTH    = ROWS * COLS;
   localparam int PIX_BITS = 3 * WIDTH;
   localparam int ROW_BITS = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam int COL_BITS = (COLS > 1) ? $clog2(COLS) : 1;

   localparam logic [ROW_BITS-1:0] ROW_LAST = ROW_BITS'(ROWS - 1);
   localparam logic [COL_BITS-1:0] COL_LAST = COL_BITS'(COLS - 1);

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_CAPTURE = 2'd1;
   localparam logic [1:0] S_FETCH   = 2'd2;
   localparam logic [1:0] S_PRESENT = 2'd3;

   logic [1:0]           state;
   logic [ADDR_BITS-1:0] wr_addr;
   logic [ROW_BITS-1:0]  wr_row;
   logic [COL_BITS-1:0]  wr_col;
   logic [ADDR_BITS-1:0] rd_addr;
   logic [ROW_BITS-1:0]  rd_row_q;
   logic [COL_BITS-1:0]  rd_col_q;
   logic [PIX_BITS-1:0]  rd_data_q;
   logic                 frame_ready_q;
   logic                 overflow_q;

   // Frame store; contents are deliberately not reset.
   logic [PIX_BITS-1:0]  mem [0:DEPTH-1];

   logic [PIX_BITS-1:0]  pix_in;
   logic                 arm;
   logic                 capture_wr;
   logic                 last_wr;
   logic                 rd_at_last;
   logic                 handshake;
   logic                 draining;

   assign pix_in     = {bus.r_data_in, bus.g_data_in, bus.b_data_in};
   assign arm        = (state == S_IDLE) && bus.start;
   assign capture_wr = (state == S_CAPTURE) && bus.data_in_done;
   assign last_wr    = (wr_row == ROW_LAST) && (wr_col == COL_LAST);
   assign rd_at_last = (rd_row_q == ROW_LAST) && (rd_col_q == COL_LAST);
   assign handshake  = (state == S_PRESENT) && bus.rd_ready;
   assign draining   = (state == S_FETCH) || (state == S_PRESENT);

   // Control FSM: arm, fill the buffer, then alternate fetch/present per pixel.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= S_IDLE;
      end else begin
         case (state)
            S_IDLE:    if (bus.start) state <= S_CAPTURE;
            S_CAPTURE: if (capture_wr && last_wr) state <= S_FETCH;
            S_FETCH:   state <= S_PRESENT;
            S_PRESENT: if (handshake) state <= rd_at_last ? S_IDLE : S_FETCH;
            default:   state <= S_IDLE;
         endcase
      end
   end

   // Write-side raster counters; they wrap to zero after the final pixel.
   always_ff @(posedge clk) begin
      if (reset || arm) begin
         wr_addr <= '0;
         wr_row  <= '0;
         wr_col  <= '0;
      end else if (capture_wr) begin
         wr_addr <= last_wr ? '0 : wr_addr + 1'b1;
         if (wr_col == COL_LAST) begin
            wr_col <= '0;
            wr_row <= (wr_row == ROW_LAST) ? '0 : wr_row + 1'b1;
         end else begin
            wr_col <= wr_col + 1'b1;
         end
      end
   end

   // Buffer write port; only strobes seen in CAPTURE land in memory.
   always_ff @(posedge clk) begin
      if (capture_wr) mem[wr_addr] <= pix_in;
   end

   // Read-side raster counters; they stay on the last pixel once it is accepted.
   always_ff @(posedge clk) begin
      if (reset || arm) begin
         rd_addr  <= '0;
         rd_row_q <= '0;
         rd_col_q <= '0;
      end else if (handshake && !rd_at_last) begin
         rd_addr <= rd_addr + 1'b1;
         if (rd_col_q == COL_LAST) begin
            rd_col_q <= '0;
            rd_row_q <= rd_row_q + 1'b1;
         end else begin
            rd_col_q <= rd_col_q + 1'b1;
         end
      end
   end

   // Synchronous buffer read issued in FETCH; the register holds through PRESENT.
   always_ff @(posedge clk) begin
      if (reset) begin
         rd_data_q <= '0;
      end else if (state == S_FETCH) begin
         rd_data_q <= mem[rd_addr];
      end
   end

   // One-cycle completion pulse aligned with entry into FETCH.
   always_ff @(posedge clk) begin
      if (reset) begin
         frame_ready_q <= 1'b0;
      end else begin
         frame_ready_q <= capture_wr && last_wr;
      end
   end

   // Sticky overflow: any strobe while draining is dropped and flagged.
   always_ff @(posedge clk) begin
      if (reset || arm) begin
         overflow_q <= 1'b0;
      end else if (draining && bus.data_in_done) begin
         overflow_q <= 1'b1;
      end
   end

   assign bus.busy        = (state != S_IDLE);
   assign bus.frame_ready = frame_ready_q;
   assign bus.overflow    = overflow_q;
   assign bus.rd_valid    = (state == S_PRESENT);
   assign bus.rd_data     = rd_data_q;
   assign bus.rd_row      = LINE_BITS'(rd_row_q);
   assign bus.rd_col      = LINE_BITS'(rd_col_q);
   assign bus.rd_last     = (state == S_PRESENT) && rd_at_last;

endmodule

// File: tb/tb_frame_capture.sv
// Directed bench for frame_capture with an expected-pixel scoreboard.
// Pixels are queued as they are strobed in and popped on each read handshake.
// Covers reset, idle strobes, backpressure, overflow, ignored start and mid-capture reset.
module tb_frame_capture;
   localparam int WIDTH = 8;
   localparam int ROWS  = 5;
   localparam int COLS  = 6;
   localparam int LB    = 10;
   localparam int NPIX  = ROWS * COLS;

   typedef struct packed {
      logic [3*WIDTH-1:0] d;
      logic [LB-1:0]      row;
      logic [LB-1:0]      col;
      logic               last;
   } exp_t;

   logic clk;
   logic reset;
   int   errors;
   int   checks;
   exp_t q[$];

   frame_capture_if #(.WIDTH(WIDTH), .LINE_BITS(LB)) ifc ();

   frame_capture #(
      .WIDTH(WIDTH), .ROWS(ROWS), .COLS(COLS), .ADDR_BITS(5), .LINE_BITS(LB)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (ifc.slave)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [3*WIDTH-1:0] pix(input int i, input int off);
      logic [WIDTH-1:0] r, g, b;
      r = WIDTH'(i + off);
      g = WIDTH'(i + 1 + off);
      b = WIDTH'(i + 2 + off);
      return {r, g, b};
   endfunction

   task automatic check_idle_outputs(input string tag);
      chk({tag, "_busy"},   32'(ifc.busy), 32'd0);
      chk({tag, "_fready"}, 32'(ifc.frame_ready), 32'd0);
      chk({tag, "_ovf"},    32'(ifc.overflow), 32'd0);
      chk({tag, "_valid"},  32'(ifc.rd_valid), 32'd0);
      chk({tag, "_last"},   32'(ifc.rd_last), 32'd0);
      chk({tag, "_data"},   32'(ifc.rd_data), 32'd0);
      chk({tag, "_row"},    32'(ifc.rd_row), 32'd0);
      chk({tag, "_col"},    32'(ifc.rd_col), 32'd0);
   endtask

   // Arm, then strobe n pixels with random gaps; start_after pulses start mid-capture.
   task automatic capture(input int off, input int n, input int start_after);
      exp_t e;
      logic [3*WIDTH-1:0] p;
      ifc.start = 1'b1;
      ifc.data_in_done = 1'b1;
      {ifc.r_data_in, ifc.g_data_in, ifc.b_data_in} = 24'hEEEEEE;
      tick();
      ifc.start = 1'b0;
      ifc.data_in_done = 1'b0;
      chk("start_busy", 32'(ifc.busy), 32'd1);
      chk("start_ovf_clear", 32'(ifc.overflow), 32'd0);
      for (int i = 0; i < n; i++) begin
         repeat ($urandom_range(3, 0)) tick();
         p = pix(i, off);
         {ifc.r_data_in, ifc.g_data_in, ifc.b_data_in} = p;
         ifc.data_in_done = 1'b1;
         e.d    = p;
         e.row  = LB'(i / COLS);
         e.col  = LB'(i % COLS);
         e.last = (i == NPIX - 1);
         q.push_back(e);
         tick();
         ifc.data_in_done = 1'b0;
         if (i == NPIX - 1) begin
            chk("frame_ready_pulse", 32'(ifc.frame_ready), 32'd1);
            chk("fetch_no_valid", 32'(ifc.rd_valid), 32'd0);
         end else begin
            chk("frame_ready_early", 32'(ifc.frame_ready), 32'd0);
         end
         if (i == start_after) begin
            ifc.start = 1'b1;
            tick();
            ifc.start = 1'b0;
         end
      end
      if (n == NPIX) begin
         tick();
         chk("frame_ready_drop", 32'(ifc.frame_ready), 32'd0);
         chk("first_valid", 32'(ifc.rd_valid), 32'd1);
      end
   endtask

   // Read the frame, comparing each presented pixel to the scoreboard head.
   task automatic drain(input int hold_idx, input int hold_n, input int ovf_idx,
                        input int start_idx, input logic exp_ovf);
      int   n_read = 0;
      int   cyc = 0;
      int   held = 0;
      bit   prev_hs = 0;
      bit   ovf_pend = 0;
      exp_t e;
      while (n_read < NPIX && cyc < 600) begin
         ifc.data_in_done = 1'b0;
         ifc.start = 1'b0;
         if (prev_hs) chk("valid_gap", 32'(ifc.rd_valid), 32'd0);
         prev_hs = 0;
         if (ifc.rd_valid) begin
            e = q[0];
            chk("rd_data", 32'(ifc.rd_data), 32'(e.d));
            chk("rd_row",  32'(ifc.rd_row),  32'(e.row));
            chk("rd_col",  32'(ifc.rd_col),  32'(e.col));
            chk("rd_last", 32'(ifc.rd_last), 32'(e.last));
            if (n_read == hold_idx && held < hold_n) begin
               ifc.rd_ready = 1'b0;
               held++;
            end else begin
               ifc.rd_ready = 1'b1;
            end
            if (n_read == ovf_idx && !ovf_pend) begin
               {ifc.r_data_in, ifc.g_data_in, ifc.b_data_in} = 24'hAABBCC;
               ifc.data_in_done = 1'b1;
               ovf_pend = 1;
               ovf_idx = -1;
            end
            if (n_read == start_idx) begin
               ifc.start = 1'b1;
               start_idx = -1;
            end
            if (ifc.rd_ready) begin
               void'(q.pop_front());
               n_read++;
               prev_hs = 1;
            end
         end else begin
            ifc.rd_ready = 1'b1;
         end
         tick();
         cyc++;
         if (ovf_pend) begin
            chk("overflow_set", 32'(ifc.overflow), 32'd1);
            ovf_pend = 0;
         end
      end
      ifc.data_in_done = 1'b0;
      ifc.start = 1'b0;
      chk("drain_count", 32'(n_read), 32'(NPIX));
      chk("end_busy", 32'(ifc.busy), 32'd0);
      chk("end_valid", 32'(ifc.rd_valid), 32'd0);
      chk("end_overflow", 32'(ifc.overflow), 32'(exp_ovf));
   endtask

   initial begin
      clk = 1'b0;
      reset = 1'b1;
      errors = 0;
      checks = 0;
      ifc.r_data_in = '0;
      ifc.g_data_in = '0;
      ifc.b_data_in = '0;
      ifc.data_in_done = 1'b0;
      ifc.start = 1'b0;
      ifc.rd_ready = 1'b1;
      repeat (3) tick();
      reset = 1'b0;
      tick();
      check_idle_outputs("reset");

      // Strobes without start must not wake the block.
      for (int i = 0; i < 10; i++) begin
         {ifc.r_data_in, ifc.g_data_in, ifc.b_data_in} = pix(i, 0);
         ifc.data_in_done = 1'b1;
         tick();
         chk("idle_busy", 32'(ifc.busy), 32'd0);
         chk("idle_fready", 32'(ifc.frame_ready), 32'd0);
         chk("idle_valid", 32'(ifc.rd_valid), 32'd0);
      end
      ifc.data_in_done = 1'b0;
      tick();

      // Normal frame with 5-cycle stall on pixel 7.
      capture(0, NPIX, -1);
      drain(7, 5, -1, -1, 1'b0);
      repeat (2) tick();

      // Ignored start in CAPTURE and PRESENT, plus an overflow strobe.
      capture(8'h20, NPIX, 3);
      drain(-1, 0, 10, 15, 1'b1);
      repeat (2) tick();

      // Abort mid-capture with reset; the new start also clears overflow.
      capture(8'h40, 12, -1);
      q.delete();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check_idle_outputs("midreset");
      tick();

      capture(8'h60, NPIX, -1);
      drain(-1, 0, -1, -1, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
